// File: rtl/prbs_delay_scheduler.sv
// prbs_delay_scheduler
// Round-robin arbiter sharing one 31-bit PRBS (x^31 + x^28 + 1) among NUM_REQ
// requesters. Each grant draws one PRBS word, reduces it to
// sat(delay_min + (prbs & delay_mask)) and returns it over valid/ready.
// Optional build macro PRBS_SEED_EN adds seed_wr/seed_data for reseeding.
//
// state | meaning
// IDLE  | waiting for a request while enable=1; a grant happens here
// RESP  | response held on resp_*, waiting for resp_ready

module prbs_delay_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DELAY_WIDTH = 16,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [DELAY_WIDTH-1:0] delay_min,
  input  logic [DELAY_WIDTH-1:0] delay_mask,
  output logic                   resp_valid,
  output logic [ID_W-1:0]        resp_id,
  output logic [DELAY_WIDTH-1:0] resp_delay,
  input  logic                   resp_ready,
  output logic                   busy
`ifdef PRBS_SEED_EN
  ,
  input  logic                   seed_wr,
  input  logic [30:0]            seed_data
`endif
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   grant;
  logic [30:0]            prbs_s;
  logic [30:0]            prbs_n;
  logic [DELAY_WIDTH-1:0] prbs_word;
  logic [DELAY_WIDTH:0]   sum;
  logic [DELAY_WIDTH-1:0] delay_sat;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        winner;
  logic [ID_W-1:0]        winner_inc;
  logic                   found;
  int                     idx;

  // PRBS next-state and the reduced word taken from it
  always_comb begin
    prbs_n        = '0;
    prbs_n[30:3]  = prbs_s[30:3] ^ prbs_s[27:0];
    prbs_n[2:0]   = prbs_s[2:0] ^ prbs_n[30:28];
    prbs_word     = ~prbs_n[DELAY_WIDTH-1:0];
  end

  // Delay reduction: add at one extra bit, saturate on carry
  always_comb begin
    sum       = {1'b0, delay_min} + {1'b0, prbs_word & delay_mask};
    delay_sat = sum[DELAY_WIDTH] ? {DELAY_WIDTH{1'b1}} : sum[DELAY_WIDTH-1:0];
  end

  // Round-robin search upward from rr_ptr, wrapping at NUM_REQ
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
    winner_inc = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  end

  assign grant = (state == IDLE) && enable && found;

  // FSM next state and outputs
  always_comb begin
    state_nxt  = state;
    resp_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (grant) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        busy       = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Response capture and round-robin pointer update on grant
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_id    <= '0;
      resp_delay <= '0;
      rr_ptr     <= '0;
    end else if (grant) begin
      resp_id    <= winner;
      resp_delay <= delay_sat;
      rr_ptr     <= winner_inc;
    end
  end

  // PRBS register: seed load beats lock-up recovery, which beats advance
  always_ff @(posedge clk) begin
    if (reset) begin
      prbs_s <= 31'h1;
    end
`ifdef PRBS_SEED_EN
    else if (seed_wr) begin
      prbs_s <= (seed_data == 31'h0) ? 31'h1 : seed_data;
    end
`endif
    else if (prbs_s == 31'h0) begin
      prbs_s <= 31'h1;
    end else if (grant) begin
      prbs_s <= prbs_n;
    end
  end

endmodule

// File: tb/tb_prbs_delay_scheduler.sv
// Scoreboard bench for prbs_delay_scheduler: stimulus pushes hand-computed
// expected responses, a negedge monitor pops and compares on each handshake.
// Seed tests are included when PRBS_SEED_EN is defined.

module tb_prbs_delay_scheduler;

  localparam int NR = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [NR-1:0] req_valid;
  logic [DW-1:0] delay_min;
  logic [DW-1:0] delay_mask;
  logic          resp_valid;
  logic [1:0]    resp_id;
  logic [DW-1:0] resp_delay;
  logic          resp_ready;
  logic          busy;
`ifdef PRBS_SEED_EN
  logic          seed_wr;
  logic [30:0]   seed_data;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int id;
    int dly;
  } exp_t;
  exp_t sb[$];

  prbs_delay_scheduler #(.NUM_REQ(NR), .DELAY_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req_valid  (req_valid),
    .delay_min  (delay_min),
    .delay_mask (delay_mask),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_delay (resp_delay),
    .resp_ready (resp_ready),
    .busy       (busy)
`ifdef PRBS_SEED_EN
    ,
    .seed_wr    (seed_wr),
    .seed_data  (seed_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes on the next posedge
  always @(negedge clk) begin
    exp_t e;
    if (!reset && resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got id %0d delay %0d expected none", resp_id, resp_delay);
      end else begin
        e = sb.pop_front();
        chk("resp_id", int'(resp_id), e.id);
        chk("resp_delay", int'(resp_delay), e.dly);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    chk("rst_valid", int'(resp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_id", int'(resp_id), 0);
    chk("rst_delay", int'(resp_delay), 0);
  endtask

  // One request: response must appear one cycle later and be taken next edge
  task automatic single(input logic [NR-1:0] r, input int eid, input int edly);
    exp_t e;
    e.id = eid;
    e.dly = edly;
    sb.push_back(e);
    req_valid = r;
    @(posedge clk); #1;
    chk("latency_valid", int'(resp_valid), 1);
    chk("latency_busy", int'(busy), 1);
    @(posedge clk); #1;
    req_valid = '0;
    chk("accept_idle", int'(resp_valid), 0);
  endtask

  initial begin
    int n_resp;
    int cyc;
    reset      = 1'b1;
    enable     = 1'b1;
    req_valid  = '0;
    delay_min  = 16'd100;
    delay_mask = 16'h00FF;
    resp_ready = 1'b1;
`ifdef PRBS_SEED_EN
    seed_wr    = 1'b0;
    seed_data  = '0;
`endif
    @(posedge clk); #1;
    do_reset();

    // Draws from s=1: 0xF6, 0xBE, 0xB6 (s -> 0x9 -> 0x41 -> 0x249)
    single(4'b0001, 0, 346);
    single(4'b0001, 0, 290);
    single(4'b0001, 0, 282);

    // Zero mask returns delay_min but still advances the PRBS
    do_reset();
    delay_mask = 16'h0000;
    delay_min  = 16'd77;
    single(4'b0001, 0, 77);
    delay_mask = 16'h00FF;
    delay_min  = 16'd100;
    single(4'b0001, 0, 290);

    // All requesters held: order 0,1,2,3,0 at one response per 2 cycles
    do_reset();
    sb.push_back('{0, 346});
    sb.push_back('{1, 290});
    sb.push_back('{2, 282});
    sb.push_back('{3, 354});
    sb.push_back('{0, 346});
    req_valid = 4'b1111;
    n_resp = 0;
    cyc = 0;
    while (n_resp < 5 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (resp_valid) n_resp++;
    end
    chk("rr_count", n_resp, 5);
    chk("rr_cycles", cyc, 9);
    @(posedge clk); #1;
    req_valid = '0;
    chk("rr_done_idle", int'(resp_valid), 0);
    // Pointer now 1: a lone requester 2 wins, then lone 0 wins from pointer 3
    single(4'b0100, 2, 290);
    single(4'b0001, 0, 282);

    // Saturation and enable=0 holding off a grant
    do_reset();
    delay_min = 16'hFFF0;
    enable = 1'b0;
    req_valid = 4'b0001;
    repeat (3) begin
      @(posedge clk); #1;
      chk("enable0_no_grant", int'(resp_valid), 0);
    end
    enable = 1'b1;
    single(4'b0001, 0, 65535);
    delay_min = 16'd100;

    // Stall with ready low, then reset drops the pending response
    do_reset();
    resp_ready = 1'b0;
    sb.push_back('{0, 346});
    req_valid = 4'b0011;
    @(posedge clk); #1;
    chk("stall_valid0", int'(resp_valid), 1);
    enable = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall_valid", int'(resp_valid), 1);
      chk("stall_id", int'(resp_id), 0);
      chk("stall_delay", int'(resp_delay), 346);
    end
    enable = 1'b1;
    req_valid = '0;
    do_reset();
    resp_ready = 1'b1;
    single(4'b0001, 0, 346);

`ifdef PRBS_SEED_EN
    // Zero seed loads state 1, so the next draw repeats the first value
    single(4'b0001, 0, 290);
    seed_wr = 1'b1;
    seed_data = 31'h0;
    @(posedge clk); #1;
    seed_wr = 1'b0;
    single(4'b0001, 0, 346);
`endif

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
